stream_demux_rr: RTL
====================

# stream_demux_rr

Registered 1-to-N stream demultiplexer: the inverse of a mux, steering one upstream valid/ready stream to N downstream valid/ready ports in strict round-robin order. Each downstream port has a one-entry output register, so the block decouples a shared producer from N independent consumers. It sits between a single data source and a bank of parallel workers. A deterministic word-to-port mapping lets the downstream side be recombined by a matching round-robin mux.

## Interface
- W, default 8, data width in bits (W >= 1)
- N, default 4, number of downstream ports (N >= 2, need not be a power of two)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- up_valid  input  1  upstream word present
- up_ready  output  1  block accepts upstream word this cycle
- up_data  input  W  upstream word
- down_valid  output  N  bit k: port k holds a word
- down_ready  input  N  bit k: consumer k takes the word this cycle
- down_data  output  N*W  port k data at bits [k*W +: W]
- ptr  output  max(1,$clog2(N))  index of the port receiving the next accepted word
- word_cnt  output  16  count of accepted upstream words, modulo 2^16

## Operation
- Per port k: flag full[k] and register data_q[k]. down_valid[k] = full[k]. The down_data slice k = data_q[k].
- Transfers:
  - Upstream transfer: up_valid & up_ready.
  - Downstream transfer on port k: full[k] & down_ready[k].
- up_ready = !full[ptr] | down_ready[ptr]. This is combinational from down_ready[ptr] and state only; it never depends on up_valid.
- On an upstream transfer:
  - data_q[ptr] <= up_data and full[ptr] <= 1.
  - ptr <= (ptr == N-1) ? 0 : ptr+1.
  - word_cnt <= word_cnt + 1, wrapping 16'hFFFF -> 0.
- On a downstream transfer on port k with no simultaneous upstream write to k: full[k] <= 0. data_q[k] keeps its stale value.
- Simultaneous drain and refill of port ptr in one cycle: full stays 1 and data_q takes the new word. No bubble and no loss.
- Strict order: ptr never skips a port. If port ptr is full and its consumer stalls, upstream stalls even when other ports are empty. This is required so the output order is deterministic.
- Ports other than ptr drain independently, in any cycle, regardless of upstream activity.
- Protocol rules:
  - A held down_valid[k] stays asserted with stable data until it is taken.
  - Behaviour when upstream drops up_valid or changes up_data while up_ready=0 is outside the contract. The block must still not corrupt state.
- Reset, asynchronous and asserted immediately when rst_n falls, regardless of clk:
  - full = 0, down_valid = 0, data_q = 0 (down_data = 0), ptr = 0, word_cnt = 0.
  - up_ready = 1 during and after reset.
  - Buffered words are discarded mid-operation. Release is synchronous to clk; the first transfer can occur on the first rising edge after rst_n is high.

## Timing
- Latency: a word accepted at edge t is visible on down_valid/down_data right after edge t. It can be consumed at edge t+1, so the minimum is 1 cycle.
- Throughput: 1 word/cycle sustained when every consumer is always ready.
- With all ports empty and down_ready = 0, exactly N words are accepted on N consecutive edges. up_ready then falls until port ptr (= 0) drains.
- All outputs are registered except up_ready, which has a single combinational path from down_ready.

## Test plan
- Reset check: drive rst_n=0 mid-stream with ports 1 and 2 full -> immediately down_valid=0, ptr=0, word_cnt=0, up_ready=1.
- Round robin, all ready: N=4, send 8'h10..8'h17 back-to-back with down_ready=4'hF -> port k receives 8'h10+k then 8'h14+k. up_ready stays 1, word_cnt=8, ptr=0 at the end.
- Fill and stall: down_ready=0, send 8'hA0..8'hA4 -> the first four are accepted, down_valid=4'hF, and up_ready=0 holding 8'hA4. Raise down_ready[0] -> 8'hA4 enters port 0 on the same edge that 8'hA0 leaves; port 0 valid stays 1.
- Strict order: port 1 full and stalled, ports 0/2/3 empty, ptr=1 -> up_ready=0. Upstream does not advance while ports 2/3 stay empty. Release down_ready[1] -> transfer resumes into port 1.
- Independent drain: ports 0..3 full, assert down_ready=4'b1010 for one cycle -> down_valid becomes 4'b0101 and ptr is unchanged.
- Counter wrap: 65537 accepted words -> word_cnt=1, ptr=(65537 mod 4)=1.

Source files
------------

// File: rtl/stream_demux_rr_if.sv
// Purpose: handshake bundle between one upstream producer and N downstream consumers.
// Latency: none, wires only.
// Backpressure: up_ready flows toward the producer, down_ready flows from each consumer.
interface stream_demux_rr_if #(
    parameter int W = 8,
    parameter int N = 4
);
    logic             up_valid;
    logic             up_ready;
    logic [W-1:0]     up_data;
    logic [N-1:0]     down_valid;
    logic [N-1:0]     down_ready;
    logic [N*W-1:0]   down_data;

    // Producer and consumer side of the bundle (the environment around the demux).
    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data
    );

    // The demux itself.
    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data
    );
endinterface

// File: rtl/stream_demux_rr.sv
// Purpose: steer one valid/ready stream to N registered ports in strict round-robin order.
// Latency: 1 cycle from upstream acceptance to down_valid; 1 word/cycle when consumers keep up.
// Backpressure: upstream stalls whenever the port under ptr is full and its consumer is not ready.
module stream_demux_rr #(
    parameter  int W  = 8,
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    stream_demux_rr_if.slave  bus,
    output logic [PW-1:0]     ptr,
    output logic [15:0]       word_cnt
);

    logic [N-1:0] full;
    logic [W-1:0] data_q [N];
    logic         up_xfer;

    // The port under ptr can take a word if it is empty or is being drained this cycle,
    // so a full-throughput stream sees no bubble on refill.
    assign bus.up_ready = ~full[ptr] | bus.down_ready[ptr];
    assign up_xfer      = bus.up_valid & bus.up_ready;
    assign bus.down_valid = full;

    for (genvar k = 0; k < N; k++) begin : g_out
        assign bus.down_data[k*W +: W] = data_q[k];
    end

    // Per-port occupancy and data: a write to the port under ptr wins over a drain of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            for (int k = 0; k < N; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (up_xfer && (ptr == PW'(k))) begin
                    full[k]   <= 1'b1;
                    data_q[k] <= bus.up_data;
                end else if (full[k] && bus.down_ready[k]) begin
                    full[k]   <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer never skips a port, keeping the word-to-port mapping deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (up_xfer) begin
            ptr <= (ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);
        end
    end

    // Accepted-word counter, free-running modulo 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (up_xfer) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule
